// File: rtl/phys_rename_pkg.sv
// Shared rename-stage definitions: physical register file geometry,
// the physical index type and a popcount helper.
package phys_rename_pkg;

  localparam int CELLS = 128;
  localparam int PHYS_ADDR_WIDTH = $clog2(CELLS);

  typedef logic [PHYS_ADDR_WIDTH-1:0] phys_addr_t;

  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + 8'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/port_prefix_count.sv
// Exclusive prefix sum over a per-port enable vector: o_off[k] is the
// number of enabled ports strictly below port k.
module port_prefix_count #(
  parameter int N = 4,
  parameter int W = 7
) (
  input  logic [N-1:0]   i_en,
  output logic [N*W-1:0] o_off
);

  always_comb begin
    logic [W-1:0] acc;
    acc = '0;
    o_off = '0;
    for (int k = 0; k < N; k++) begin
      o_off[k*W +: W] = acc;
      acc = acc + W'(i_en[k]);
    end
  end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices for rename.
// Define PHYS_FREE_LIST_DUP_CHECK_EN to add a free bitmap catching double release.
module phys_free_list #(
  parameter int CELLS           = phys_rename_pkg::CELLS,
  parameter int ALLOC_PORTS     = 4,
  parameter int FREE_PORTS      = 4,
  parameter int RESERVED        = 0,
  parameter int PHYS_ADDR_WIDTH = $clog2(CELLS)
) (
  input  logic                                 clk,
  input  logic                                 sync_rst,
  input  logic                                 clk_en,
  input  logic [ALLOC_PORTS-1:0]               alloc_req,
  output logic                                 alloc_grant,
  output logic [ALLOC_PORTS*PHYS_ADDR_WIDTH-1:0] alloc_addr,
  input  logic [FREE_PORTS-1:0]                rel_en,
  input  logic [FREE_PORTS*PHYS_ADDR_WIDTH-1:0]  rel_addr,
  output logic [PHYS_ADDR_WIDTH:0]             free_count,
  output logic                                 err
);
  import phys_rename_pkg::*;

  localparam int AW = PHYS_ADDR_WIDTH;
  localparam int CW = AW + 2;

  typedef logic [AW-1:0] idx_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [CW-1:0] wide_t;

  idx_t r_ring [CELLS];
  idx_t r_head;
  idx_t r_tail;
  cnt_t r_free_count;
  logic r_err;

  logic [ALLOC_PORTS*AW-1:0] w_aoff;
  logic [FREE_PORTS*AW-1:0]  w_roff;
  logic [FREE_PORTS-1:0]     w_rel_en;
  idx_t  w_aidx [ALLOC_PORTS];
  idx_t  w_ridx [FREE_PORTS];
  wide_t w_n_req;
  wide_t w_n_rel;
  wide_t w_cnt_alloc;
  wide_t w_cnt_next;
  logic  w_grant;
  logic  w_ovf;
  logic  w_dup;
  logic  w_rel_ok;

  assign w_rel_en = clk_en ? rel_en : '0;
  assign w_n_req  = CW'(popcount(64'(alloc_req)));
  assign w_n_rel  = CW'(popcount(64'(w_rel_en)));

  assign w_grant = clk_en && !sync_rst && (w_n_req != '0) &&
                   (wide_t'(r_free_count) >= w_n_req);

  port_prefix_count #(.N(ALLOC_PORTS), .W(AW)) u_alloc_off (
    .i_en  (alloc_req),
    .o_off (w_aoff)
  );

  port_prefix_count #(.N(FREE_PORTS), .W(AW)) u_rel_off (
    .i_en  (w_rel_en),
    .o_off (w_roff)
  );

  for (genvar k = 0; k < ALLOC_PORTS; k++) begin : g_alloc
    assign w_aidx[k] = r_head + w_aoff[k*AW +: AW];
    assign alloc_addr[k*AW +: AW] = r_ring[w_aidx[k]];
  end

  for (genvar p = 0; p < FREE_PORTS; p++) begin : g_rel
    assign w_ridx[p] = r_tail + w_roff[p*AW +: AW];
  end

  assign w_cnt_alloc = wide_t'(r_free_count) - (w_grant ? w_n_req : '0);
  assign w_cnt_next  = w_cnt_alloc + w_n_rel;
  assign w_ovf       = w_cnt_next > wide_t'(CELLS);
  assign w_rel_ok    = !w_ovf && !w_dup;

`ifdef PHYS_FREE_LIST_DUP_CHECK_EN
  logic [CELLS-1:0] r_bitmap;
  logic [CELLS-1:0] w_bm_next;

  always_comb begin
    w_dup = 1'b0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      if (w_rel_en[p]) begin
        if (r_bitmap[rel_addr[p*AW +: AW]]) w_dup = 1'b1;
        for (int q = 0; q < p; q++) begin
          if (w_rel_en[q] &&
              rel_addr[q*AW +: AW] == rel_addr[p*AW +: AW])
            w_dup = 1'b1;
        end
      end
    end
  end

  // Allocation clears are applied before release sets.
  always_comb begin
    w_bm_next = r_bitmap;
    if (w_grant) begin
      for (int k = 0; k < ALLOC_PORTS; k++) begin
        if (alloc_req[k]) w_bm_next[alloc_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (w_rel_ok) begin
      for (int p = 0; p < FREE_PORTS; p++) begin
        if (w_rel_en[p]) w_bm_next[rel_addr[p*AW +: AW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < CELLS; i++) begin
        r_bitmap[i] <= (i >= RESERVED);
      end
    end else if (clk_en) begin
      r_bitmap <= w_bm_next;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_head       <= '0;
      r_tail       <= idx_t'((CELLS - RESERVED) % CELLS);
      r_free_count <= cnt_t'(CELLS - RESERVED);
      r_err        <= 1'b0;
      for (int i = 0; i < CELLS; i++) begin
        r_ring[i] <= idx_t'((RESERVED + i) % CELLS);
      end
    end else if (clk_en) begin
      if (w_grant) r_head <= r_head + idx_t'(w_n_req);
      if (w_rel_ok) begin
        r_tail       <= r_tail + idx_t'(w_n_rel);
        r_free_count <= cnt_t'(w_cnt_next);
        for (int p = 0; p < FREE_PORTS; p++) begin
          if (w_rel_en[p]) r_ring[w_ridx[p]] <= rel_addr[p*AW +: AW];
        end
      end else begin
        r_free_count <= cnt_t'(w_cnt_alloc);
        r_err        <= 1'b1;
      end
    end
  end

  assign alloc_grant = w_grant;
  assign free_count  = r_free_count;
  assign err         = r_err;

endmodule
